// File: rtl/fifo_pkt_reader.sv
// Reads fixed-size packets out of a first-word-fall-through FIFO into a registered
// valid/ready stream with SOP/EOP framing. Define FIFO_PKT_CHECKSUM_EN to add an XOR checksum check.
module fifo_pkt_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PKT_SIZE   = 10
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic                  EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  R_INC,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  OUT_SOP,
    output logic                  OUT_EOP,
    output logic                  CHK_ERR
);

    localparam int unsigned CntWidth = (PKT_SIZE > 1) ? $clog2(PKT_SIZE) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(PKT_SIZE - 1);

    typedef enum logic {StIdle, StBody} state_t;

    state_t              state_q;
    logic [CntWidth-1:0] cnt_q;
    logic                last_word;

    // Gated by reset so no pop can escape while the block is held in reset.
    always_comb begin
        R_INC     = R_RST && !EMPTY && (!OUT_VALID || OUT_READY);
        last_word = (state_q == StBody) && (cnt_q == CntLast);
    end

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
            OUT_SOP   <= 1'b0;
            OUT_EOP   <= 1'b0;
        end else if (R_INC) begin
            OUT_DATA  <= RD_DATA;
            OUT_VALID <= 1'b1;
            case (state_q)
                StIdle: begin
                    OUT_SOP <= 1'b1;
                    OUT_EOP <= 1'b0;
                    cnt_q   <= CntWidth'(1);
                    state_q <= StBody;
                end
                default: begin
                    OUT_SOP <= 1'b0;
                    if (cnt_q == CntLast) begin
                        OUT_EOP <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        OUT_EOP <= 1'b0;
                        cnt_q   <= cnt_q + CntWidth'(1);
                    end
                end
            endcase
        end else if (OUT_VALID && OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

`ifdef FIFO_PKT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] xor_q;
    logic                  chk_q;

    // The running XOR restarts from word 0 so it covers words 0..PKT_SIZE-2 at the last pop.
    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            xor_q <= '0;
            chk_q <= 1'b0;
        end else begin
            if (state_q == StIdle) begin
                xor_q <= R_INC ? RD_DATA : '0;
            end else if (R_INC) begin
                xor_q <= xor_q ^ RD_DATA;
            end
            if (R_INC) begin
                chk_q <= last_word ? (xor_q != RD_DATA) : 1'b0;
            end
        end
    end

    assign CHK_ERR = chk_q;
`else
    logic unused_last;
    assign unused_last = last_word;
    assign CHK_ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed and randomised bench for fifo_pkt_reader with a behavioural FWFT FIFO model.
module tb_fifo_pkt_reader;

    logic       R_CLK = 1'b0;
    logic       R_RST;
    logic       EMPTY;
    logic [7:0] RD_DATA;
    logic       R_INC;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic       OUT_SOP;
    logic       OUT_EOP;
    logic       CHK_ERR;

    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    logic       force_empty = 1'b0;
    int         total = 0;
    int         passed = 0;

    fifo_pkt_reader #(.DATA_WIDTH(8), .PKT_SIZE(10)) dut (
        .R_CLK(R_CLK), .R_RST(R_RST), .EMPTY(EMPTY), .RD_DATA(RD_DATA), .R_INC(R_INC),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_SOP(OUT_SOP), .OUT_EOP(OUT_EOP), .CHK_ERR(CHK_ERR)
    );

    always #5 R_CLK = ~R_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic apply();
        EMPTY   = force_empty || (q.size() == 0);
        RD_DATA = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    // Advance one clock; the FIFO model pops if R_INC was high before the edge.
    task automatic cyc();
        logic p;
        #1;
        p = R_INC;
        @(posedge R_CLK);
        #1;
        if (p) q.delete(0);
        apply();
    endtask

    task automatic push_range(input int first, input int last);
        for (int v = first; v <= last; v++) q.push_back(8'(v));
        apply();
    endtask

    task automatic run_words(input string tag, input int first, input int n, input int sop_idx,
                             input int eop_idx);
        for (int i = 0; i < n; i++) begin
            #1;
            check({tag, "_rinc"}, R_INC, 1);
            cyc();
            check({tag, "_data"}, OUT_DATA, first + i);
            check({tag, "_valid"}, OUT_VALID, 1);
            check({tag, "_sop"}, OUT_SOP, (i == sop_idx) ? 1 : 0);
            check({tag, "_eop"}, OUT_EOP, (i == eop_idx) ? 1 : 0);
        end
    endtask

    initial begin
        int acc;
        int cycles;
        logic a, s, e;
        logic [7:0] d;
        logic [7:0] w;

        R_RST = 1'b0;
        OUT_READY = 1'b1;
        push_range(1, 10);
        #2;
        check("rst_valid", OUT_VALID, 0);
        check("rst_data", OUT_DATA, 0);
        check("rst_sop_eop", {OUT_SOP, OUT_EOP}, 0);
        check("rst_rinc", R_INC, 0);
        @(posedge R_CLK);
        #1;
        R_RST = 1'b1;

        // Back-to-back packet
        run_words("b2b", 1, 10, 0, 9);
        #1;
        check("b2b_rinc_empty", R_INC, 0);
        cyc();
        check("b2b_drain_valid", OUT_VALID, 0);

        // Backpressure after word 3
        push_range(1, 10);
        run_words("bp_pre", 1, 3, 0, 99);
        OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_rinc", R_INC, 0);
            cyc();
            check("bp_hold_data", OUT_DATA, 3);
            check("bp_hold_valid", OUT_VALID, 1);
        end
        OUT_READY = 1'b1;
        run_words("bp_post", 4, 7, 99, 6);
        cyc();

        // Underflow after word 4
        push_range(1, 4);
        run_words("uf_pre", 1, 4, 0, 99);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("uf_rinc", R_INC, 0);
            cyc();
        end
        check("uf_valid_clr", OUT_VALID, 0);
        push_range(5, 10);
        run_words("uf_post", 5, 6, 99, 5);
        cyc();

        // Reset mid-packet
        push_range(1, 14);
        run_words("mr_pre", 1, 4, 0, 99);
        #2;
        R_RST = 1'b0;
        #1;
        check("mr_valid", OUT_VALID, 0);
        check("mr_data", OUT_DATA, 0);
        check("mr_sop_eop_chk", {OUT_SOP, OUT_EOP, CHK_ERR}, 0);
        check("mr_rinc", R_INC, 0);
        cyc();
        check("mr_held_data", OUT_DATA, 0);
        R_RST = 1'b1;
        run_words("mr_post", 5, 10, 0, 9);
        cyc();

        // Checksum: good then bad last word
        push_range(1, 9);
        q.push_back(8'h01);
        push_range(1, 9);
        q.push_back(8'h02);
        push_range(32, 41);
        for (int i = 0; i < 10; i++) cyc();
        check("ck_good_eop", OUT_EOP, 1);
        check("ck_good_chk", CHK_ERR, 0);
        for (int i = 0; i < 10; i++) cyc();
        check("ck_bad_eop", OUT_EOP, 1);
`ifdef FIFO_PKT_CHECKSUM_EN
        check("ck_bad_chk", CHK_ERR, 1);
`else
        check("ck_bad_chk", CHK_ERR, 0);
`endif
        cyc();
        check("ck_clr_data", OUT_DATA, 32);
        check("ck_clr_chk", CHK_ERR, 0);
        for (int i = 0; i < 10; i++) cyc();
        check("ck_drain_valid", OUT_VALID, 0);

        // Random EMPTY/OUT_READY over 50 packets
        for (int i = 0; i < 500; i++) begin
            w = 8'($urandom_range(0, 255));
            q.push_back(w);
            exp_q.push_back(w);
        end
        acc = 0;
        cycles = 0;
        while (acc < 500 && cycles < 20000) begin
            force_empty = ($urandom_range(0, 3) == 0);
            OUT_READY = ($urandom_range(0, 3) != 0);
            apply();
            #1;
            a = OUT_VALID && OUT_READY;
            d = OUT_DATA;
            s = OUT_SOP;
            e = OUT_EOP;
            cyc();
            cycles++;
            if (a) begin
                check("rnd_data", d, exp_q[0]);
                check("rnd_sop", s, (acc % 10 == 0) ? 1 : 0);
                check("rnd_eop", e, (acc % 10 == 9) ? 1 : 0);
                exp_q.delete(0);
                acc++;
            end
        end
        check("rnd_accepted", acc, 500);
        force_empty = 1'b0;
        OUT_READY = 1'b1;
        apply();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
